debounce_sync: RTL and testbench

//   Conditions a raw asynchronous input (pushbutton, switch, off-chip pin) before it drives the buffer stage.
//   - Synchronizes the input into the clk domain.
//   - Rejects pulses shorter than a programmable count.
//   - Outputs a clean level plus single-cycle rise/fall strobes.
//   - Its y output feeds the buffer's a input directly.
//

---
 rtl/debounce_sync.sv | 169 ++++++++++++++++
 tb/tb_debounce_sync.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync
//   Conditions a raw asynchronous input (pushbutton, switch, off-chip pin)
//   before it drives the buffer stage. The input is brought into the clk
//   domain through a plain flop chain. A new level is accepted only after it
//   has been seen for DEBOUNCE consecutive cycles. The block then presents a
//   clean registered level plus single-cycle rise/fall strobes.
//
//   Parameters
//     SYNC_STAGES  flops in the synchronizer chain (>= 2)
//     CNT_W        debounce counter width
//     DEBOUNCE     consecutive stable cycles needed to accept a level
//                  (1 .. 2**CNT_W-1)
//
//   Ports
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     a      in   raw input, asynchronous to clk, may bounce
//     y      out  debounced, synchronized level (registered)
//     rise   out  one-cycle strobe in the cycle y goes 0->1
//     fall   out  one-cycle strobe in the cycle y goes 1->0
//     busy   out  high while a candidate level change is being timed
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_STABLE  | synchronized input agrees with y, counter held at 0
//   ST_PENDING | synchronized input differs from y, counting agreeing cycles
module debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int DEBOUNCE    = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall,
   output logic busy
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("debounce_sync: SYNC_STAGES must be at least 2");
      end
      if (DEBOUNCE < 1) begin : g_bad_deb_lo
         $error("debounce_sync: DEBOUNCE must be at least 1");
      end
      if (DEBOUNCE > (2**CNT_W) - 1) begin : g_bad_deb_hi
         $error("debounce_sync: DEBOUNCE does not fit in CNT_W bits");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);
   // With DEBOUNCE==1 a single mismatching cycle is already enough, so the
   // level is taken straight from ST_STABLE without visiting ST_PENDING.
   localparam bit               SINGLE_CY = (DEBOUNCE == 1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   state_t                 state_q, state_nxt;
   logic [CNT_W-1:0]       cnt_q, cnt_nxt;
   logic                   y_q, y_nxt;
   logic                   rise_q, rise_nxt;
   logic                   fall_q, fall_nxt;
   logic                   busy_q;
   logic                   mismatch;

   // Plain shift chain; nothing may sit between stages so every stage gets a
   // full cycle to resolve metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], a};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign mismatch = (s != y_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE;
         cnt_q   <= CNT_ZERO;
         y_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         y_q     <= y_nxt;
         rise_q  <= rise_nxt;
         fall_q  <= fall_nxt;
         busy_q  <= (state_nxt == ST_PENDING);
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      y_nxt     = y_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;

      case (state_q)
         ST_STABLE: begin
            cnt_nxt = CNT_ZERO;
            if (mismatch) begin
               if (SINGLE_CY) begin
                  y_nxt    = s;
                  rise_nxt = s;
                  fall_nxt = ~s;
               end else begin
                  state_nxt = ST_PENDING;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end

         ST_PENDING: begin
            if (!mismatch) begin
               // Input fell back to the current level: treat it as a glitch.
               state_nxt = ST_STABLE;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = CNT_ZERO;
               y_nxt     = s;
               rise_nxt  = s;
               fall_nxt  = ~s;
            end else begin
               cnt_nxt = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   assign y    = y_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

   a_strobe_excl : assert property (
      @(posedge clk) disable iff (!rst_n) !(rise_q && fall_q));

   a_cnt_bound : assert property (
      @(posedge clk) disable iff (!rst_n) (cnt_q <= CNT_LAST));

   a_rise_level : assert property (
      @(posedge clk) disable iff (!rst_n) rise_q |-> y_q);

   a_fall_level : assert property (
      @(posedge clk) disable iff (!rst_n) fall_q |-> !y_q);

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

   localparam int LAT = 12;

   logic clk;
   logic rst_n;
   logic a;
   logic y;
   logic rise;
   logic fall;
   logic busy;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   typedef struct {
      bit is_rise;
      int at_cyc;
   } ev_t;

   ev_t exp_q[$];

   debounce_sync #(
      .SYNC_STAGES(2),
      .CNT_W      (4),
      .DEBOUNCE   (10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .y    (y),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_rise, input int at_cyc);
      ev_t e;
      e.is_rise = is_rise;
      e.at_cyc  = at_cyc;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe the DUT raises must match the next expected event
   // in type, cycle and the level of y at that moment.
   always @(negedge clk) begin
      if (rise || fall) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got rise=%0b fall=%0b y=%0b at cycle %0d, expected no strobe",
                     rise, fall, y, cyc);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (rise !== e.is_rise || fall !== !e.is_rise || y !== e.is_rise || cyc != e.at_cyc) begin
               miscompares++;
               $display("FAIL strobe: got rise=%0b fall=%0b y=%0b at cycle %0d, expected rise=%0b fall=%0b y=%0b at cycle %0d",
                        rise, fall, y, cyc, e.is_rise, !e.is_rise, e.is_rise, e.at_cyc);
            end
         end
      end
   end

   // Change a between edges and hold it: y follows on edge 12, busy spans
   // edges 3..11.
   task automatic transition(input logic lvl);
      int c0;
      c0 = cyc;
      a  = lvl;
      push_ev(lvl, c0 + LAT);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk("xfer_busy", busy, logic'(k >= 3 && k <= 11));
         chk("xfer_y", y, (k >= LAT) ? lvl : ~lvl);
      end
   endtask

   int dur[4] = '{3, 2, 4, 1};

   initial begin
      int c0;
      rst_n = 1'b0;
      a     = 1'b0;

      @(negedge clk);
      chk("rst_y", y, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // idle with a=0
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("idle_y", y, 1'b0);
         chk("idle_busy", busy, 1'b0);
         chk("idle_rise", rise, 1'b0);
         chk("idle_fall", fall, 1'b0);
      end

      // clean rise, then clean fall
      transition(1'b1);
      transition(1'b0);

      // a high for only 9 edges: one short of acceptance
      a = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk("short_busy", busy, logic'(k >= 3));
         chk("short_y", y, 1'b0);
      end
      a = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         chk("short_busy2", busy, logic'(k <= 2));
         chk("short_y2", y, 1'b0);
      end

      // bounce sequence, then settle high
      for (int i = 0; i < 4; i++) begin
         a = (i % 2 == 0) ? 1'b1 : 1'b0;
         for (int k = 0; k < dur[i]; k++) begin
            @(negedge clk);
            chk("bounce_y", y, 1'b0);
         end
      end
      c0 = cyc;
      a  = 1'b1;
      push_ev(1'b1, c0 + LAT);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk("bounce_settle_y", y, logic'(k >= LAT));
      end

      transition(1'b0);

      // reset in the middle of a pending change
      a = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_y", y, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_cnt", logic'(dut.cnt_q == 4'd0), 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      push_ev(1'b1, c0 + LAT);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk("postrst_y", y, logic'(k >= LAT));
         chk("postrst_busy", busy, logic'(k >= 3 && k <= 11));
      end

      repeat (5) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_strobe: got %0d outstanding events, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
